// File: rtl/pt2272_symbol_demod_pkg.sv
// pt2272_pkg
// Shared types and constants for the PT2272 receive front end.
//   state_t        : demodulator FSM states
//   pw_t           : pulse-width class of a measured high or low interval
//   SYM_*          : 2-bit tri-state symbol codes sent to the shift register
//   OP_*           : shift-register operation codes
//   classify_width : maps a width in clk cycles onto the short/long windows
package pt2272_pkg;

  typedef enum logic [1:0] {
    SYNC_HUNT = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PW_NONE  = 2'd0,
    PW_SHORT = 2'd1,
    PW_LONG  = 2'd2
  } pw_t;

  localparam logic [1:0] SYM_0 = 2'b00;
  localparam logic [1:0] SYM_1 = 2'b11;
  localparam logic [1:0] SYM_F = 2'b01;

  localparam logic [2:0] OP_SHL1 = 3'b001;
  localparam logic [2:0] OP_SHR1 = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_SHL2 = 3'b100;
  localparam logic [2:0] OP_SHR2 = 3'b101;

  // Short window is [2a,6a], long window is [8a,16a]; the gap between them
  // and anything above 16a are malformed.
  function automatic pw_t classify_width(input logic [31:0] w,
                                         input logic [31:0] alpha);
    if (w >= 2 * alpha && w <= 6 * alpha) return PW_SHORT;
    if (w >= 8 * alpha && w <= 16 * alpha) return PW_LONG;
    return PW_NONE;
  endfunction

endpackage

// File: rtl/pt2272_symbol_demod_if.sv
// pt2272_symbol_demod_if
// Bundles the RF input and the symbol stream towards the shift register.
//   din        : raw RF data line (asynchronous to clk)
//   sym_bits   : 2-bit symbol code, held between strobes
//   sym_valid  : one-cycle strobe qualifying sym_bits
//   shreg_op   : shift-register operation (constant shift-left-by-two)
//   frame_done : one-cycle pulse coincident with the last symbol strobe
//   err        : one-cycle pulse on a malformed pulse or symbol
// Handshake: sym_valid is a pure valid strobe with no ready/backpressure;
// sym_bits and frame_done are meaningful only in the cycle sym_valid is 1,
// and the consumer must accept every strobe.
// Modports: master = RF source / symbol consumer side, slave = demodulator.
interface pt2272_symbol_demod_if;
  logic       din;
  logic [1:0] sym_bits;
  logic       sym_valid;
  logic [2:0] shreg_op;
  logic       frame_done;
  logic       err;

  modport master (
    output din,
    input  sym_bits, sym_valid, shreg_op, frame_done, err
  );

  modport slave (
    input  din,
    output sym_bits, sym_valid, shreg_op, frame_done, err
  );
endinterface

// File: rtl/pt2272_symbol_demod_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops clear to 0
//   i_d : asynchronous input
//   o_q : synchronised output, two clk cycles behind i_d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pt2272_symbol_demod.sv
// pt2272_symbol_demod
// Receive front end of the PT2272 decoder: synchronises the RF line,
// measures every high/low interval in clk cycles, classifies it as a short
// or long pulse, pairs pulses into tri-state symbols and strobes them to
// the downstream shift register. A frame is SYMBOLS symbols preceded by a
// sync gap (low of at least SYNC_MIN_A alpha).
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : slave side of pt2272_symbol_demod_if (din in, symbols out)
//   o_dbg_state : current FSM state
module pt2272_symbol_demod
  import pt2272_pkg::*;
#(
  parameter int ALPHA      = 4,
  parameter int SYMBOLS    = 12,
  parameter int SYNC_MIN_A = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pt2272_symbol_demod_if.slave   bus,
  output state_t                 o_dbg_state
);

  localparam int SAT = SYNC_MIN_A * ALPHA;
  localparam int CW  = $clog2(SAT + 1);
  localparam int SCW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  localparam logic [CW-1:0]  C_SAT      = CW'(SAT);
  localparam logic [CW-1:0]  C_LONG_MAX = CW'(16 * ALPHA);
  localparam logic [SCW-1:0] C_LAST_SYM = SCW'(SYMBOLS - 1);

  logic          w_din_s;
  logic          r_din_d;
  logic          w_rise;
  logic          w_fall;
  logic [CW-1:0] r_cnt;
  pw_t           w_cls;
  logic          w_bit;
  logic          w_low_ok;

  state_t         r_state;
  logic [SCW-1:0] r_sym_cnt;
  logic           r_half;
  logic           r_b0;
  logic           r_hi_bit;
  logic [1:0]     r_sym_bits;
  logic           r_sym_valid;
  logic           r_frame_done;
  logic           r_err;

  sync_2ff u_din_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.din),
    .o_q (w_din_s)
  );

  assign w_rise = w_din_s & ~r_din_d;
  assign w_fall = ~w_din_s & r_din_d;

  // cnt equals the width of the level that just ended in the cycle its
  // closing edge is seen; it saturates so a long idle low reads as "sync".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_din_d <= w_din_s;
      if (w_rise || w_fall) begin
        r_cnt <= CW'(1);
      end else if (r_cnt != C_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_cls = classify_width(32'(r_cnt), 32'(ALPHA));
  assign w_bit = (w_cls == PW_LONG);

  // The low following a pulse must be the opposite length of its high.
  assign w_low_ok = r_hi_bit ? (w_cls == PW_SHORT) : (w_cls == PW_LONG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SYNC_HUNT;
      r_sym_cnt    <= '0;
      r_half       <= 1'b0;
      r_b0         <= 1'b0;
      r_hi_bit     <= 1'b0;
      r_sym_bits   <= SYM_0;
      r_sym_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sym_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        SYNC_HUNT: begin
          if (w_rise && r_cnt == C_SAT) begin
            r_state   <= HIGH;
            r_sym_cnt <= '0;
            r_half    <= 1'b0;
          end
        end
        HIGH: begin
          if (w_fall) begin
            if (w_cls == PW_NONE) begin
              r_err   <= 1'b1;
              r_state <= SYNC_HUNT;
            end else if (!r_half) begin
              r_b0     <= w_bit;
              r_hi_bit <= w_bit;
              r_half   <= 1'b1;
              r_state  <= LOW;
            end else if ({r_b0, w_bit} == 2'b10) begin
              // Long-then-short is not a legal tri-state code.
              r_err   <= 1'b1;
              r_state <= SYNC_HUNT;
            end else begin
              r_sym_valid <= 1'b1;
              r_sym_bits  <= {r_b0, w_bit};
              r_hi_bit    <= w_bit;
              r_half      <= 1'b0;
              if (r_sym_cnt == C_LAST_SYM) begin
                // The trailing low is left unchecked; it is the next sync.
                r_frame_done <= 1'b1;
                r_state      <= SYNC_HUNT;
              end else begin
                r_sym_cnt <= r_sym_cnt + SCW'(1);
                r_state   <= LOW;
              end
            end
          end
        end
        LOW: begin
          if (w_rise) begin
            if (w_low_ok) begin
              r_state <= HIGH;
            end else begin
              r_err   <= 1'b1;
              r_state <= SYNC_HUNT;
            end
          end else if (r_cnt > C_LONG_MAX) begin
            // cnt keeps running, so this same low can still become a sync.
            r_err   <= 1'b1;
            r_state <= SYNC_HUNT;
          end
        end
        default: begin
          r_state <= SYNC_HUNT;
        end
      endcase
    end
  end

  assign bus.sym_bits   = r_sym_bits;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.shreg_op   = OP_SHL2;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pt2272_symbol_demod.sv
// tb_pt2272_symbol_demod
// Directed-plus-random bench: drives din as a list of timed levels, records
// every din edge, and predicts the symbol/err event stream from the pulse
// widths with a pulse-level reference model.
module tb_pt2272_symbol_demod;
  import pt2272_pkg::*;

  localparam int ALPHA = 4;
  localparam int EW    = 25;

  typedef struct {
    int cyc;
    bit lvl;
    bit is_rst;
  } edge_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pt2272_symbol_demod_if bus ();
  state_t dbg_state;

  pt2272_symbol_demod #(
    .ALPHA      (ALPHA),
    .SYMBOLS    (12),
    .SYNC_MIN_A (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  edge_t         hist[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            n_cmp  = 0;
  int            n_bad  = 0;
  int            n_done = 0;
  logic [1:0]    mdl_bits;

  function automatic logic [EW-1:0] ev(input int c, input bit e, input bit fd,
                                       input bit sv, input logic [1:0] b);
    return {c[19:0], e, fd, sv, b};
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.sym_valid || bus.err || bus.frame_done))
      obs_q.push_back(ev(cyc, bus.err, bus.frame_done, bus.sym_valid, bus.sym_bits));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // 0 = malformed, 1 = short [2a,6a], 2 = long [8a,16a]
  function automatic int pclass(input int w);
    if (w >= 2 * ALPHA && w <= 6 * ALPHA) return 1;
    if (w >= 8 * ALPHA && w <= 16 * ALPHA) return 2;
    return 0;
  endfunction

  // Walks the recorded level history. Events appear 3 cycles after the din
  // edge that decides them; an over-long low is flagged once it has lasted
  // more than 16a cycles.
  task automatic run_model(input int now);
    bit hunt, half, b0, hi, b, has_next;
    int nsym, st, en, w, k;
    hunt = 1; half = 0; b0 = 0; hi = 0; nsym = 0;
    mdl_bits = SYM_0;
    exp_q.delete();
    for (int i = 0; i < hist.size(); i++) begin
      st       = hist[i].cyc;
      has_next = (i + 1 < hist.size()) && !hist[i + 1].is_rst;
      en       = (i + 1 < hist.size()) ? hist[i + 1].cyc : now;
      w        = en - st;
      if (hist[i].is_rst) begin
        hunt = 1; half = 0; mdl_bits = SYM_0;
      end
      if (hist[i].lvl) begin
        if (!hunt && has_next) begin
          k = pclass(w);
          if (k == 0) begin
            exp_q.push_back(ev(en + 3, 1, 0, 0, mdl_bits));
            hunt = 1;
          end else begin
            b = (k == 2);
            if (!half) begin
              b0 = b; half = 1; hi = b;
            end else if (b0 && !b) begin
              exp_q.push_back(ev(en + 3, 1, 0, 0, mdl_bits));
              hunt = 1;
            end else begin
              nsym++;
              mdl_bits = {b0, b};
              exp_q.push_back(ev(en + 3, 0, nsym == 12, 1, mdl_bits));
              half = 0; hi = b;
              if (nsym == 12) hunt = 1;
            end
          end
        end
      end else begin
        if (!hunt) begin
          if (w > 16 * ALPHA) begin
            exp_q.push_back(ev(st + 16 * ALPHA + 4, 1, 0, 0, mdl_bits));
            hunt = 1;
          end else if (has_next) begin
            k = pclass(w);
            if (!((hi && k == 1) || (!hi && k == 2))) begin
              exp_q.push_back(ev(en + 3, 1, 0, 0, mdl_bits));
              hunt = 1;
            end
          end
        end
        if (hunt && has_next && w >= 64 * ALPHA) begin
          hunt = 0; half = 0; nsym = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int mx;
    logic [EW-1:0] got, want;
    run_model(cyc);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    mx = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = n_done; i < mx; i++) begin
      got  = (i < obs_q.size()) ? obs_q[i] : '1;
      want = (i < exp_q.size()) ? exp_q[i] : '1;
      chk({tag, "_event"}, 32'(got), 32'(want));
    end
    n_done = mx;
    chk({tag, "_held_bits"}, 32'(bus.sym_bits), 32'(mdl_bits));
  endtask

  // ---------------- drivers ----------------
  task automatic set_level(input logic lvl, input int n);
    if (lvl !== bus.din && !rst) hist.push_back('{cyc: cyc, lvl: lvl, is_rst: 1'b0});
    bus.din = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pw(input bit lng, input bit rnd);
    if (!rnd) return lng ? 12 * ALPHA : 4 * ALPHA;
    return lng ? int'($urandom_range(15 * ALPHA, 9 * ALPHA))
               : int'($urandom_range(5 * ALPHA, 3 * ALPHA));
  endfunction

  task automatic send_sym(input logic [1:0] code, input bit rnd);
    bit b;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? code[1] : code[0];
      set_level(1'b1, pw(b, rnd));
      set_level(1'b0, pw(!b, rnd));
    end
  endtask

  function automatic logic [1:0] rand_sym();
    case ($urandom_range(2, 0))
      0:       return SYM_0;
      1:       return SYM_1;
      default: return SYM_F;
    endcase
  endfunction

  task automatic send_rand(input int n);
    for (int s = 0; s < n; s++) send_sym(rand_sym(), 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bits"},  32'(bus.sym_bits),   32'(SYM_0));
    chk({tag, "_valid"}, 32'(bus.sym_valid),  32'(0));
    chk({tag, "_done"},  32'(bus.frame_done), 32'(0));
    chk({tag, "_err"},   32'(bus.err),        32'(0));
    chk({tag, "_op"},    32'(bus.shreg_op),   32'(3'b100));
    chk({tag, "_state"}, 32'(dbg_state),      32'(SYNC_HUNT));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.din = 1'b0;
    #2 rst = 1'b1;

    // Reset held while din toggles.
    for (int t = 0; t < 6; t++) set_level(~bus.din, 7 + t);
    check_reset_outputs("rst_held");
    set_level(1'b0, 3);
    rst = 1'b0;
    hist.push_back('{cyc: cyc, lvl: 1'b0, is_rst: 1'b1});
    check_reset_outputs("rst_release");

    // No sync gap: short activity only.
    for (int t = 0; t < 8; t++) begin
      set_level(1'b1, 20);
      set_level(1'b0, 30);
    end
    set_level(1'b0, 40);
    check_all("no_sync");

    // Sync then 0, 1, f (frame abandoned by the long idle that follows).
    set_level(1'b0, 496);
    send_sym(SYM_0, 1'b0);
    send_sym(SYM_1, 1'b0);
    send_sym(SYM_F, 1'b0);
    set_level(1'b0, 300);
    check_all("s_s_l_l_s_l");

    // Two full frames of "1" separated by a 496-cycle gap.
    set_level(1'b0, 496);
    for (int s = 0; s < 12; s++) send_sym(SYM_1, 1'b0);
    set_level(1'b0, 496 - 4 * ALPHA);
    for (int s = 0; s < 12; s++) send_sym(SYM_1, 1'b0);
    set_level(1'b0, 300);
    check_all("frame_ones");

    // Illegal L,S pair, then a normal random frame on the next sync.
    set_level(1'b0, 496);
    send_sym(2'b10, 1'b0);
    set_level(1'b0, 496);
    send_rand(12);
    set_level(1'b0, 300);
    check_all("code_10");

    // High of 28 cycles, then resync on a 496-cycle low.
    set_level(1'b0, 496);
    send_sym(SYM_0, 1'b1);
    set_level(1'b1, 28);
    set_level(1'b0, 496);
    send_rand(12);
    set_level(1'b0, 300);
    check_all("high_28");

    // Mid-frame low of 100 cycles, a stray pulse, then resync.
    set_level(1'b0, 496);
    send_rand(2);
    set_level(1'b1, 16);
    set_level(1'b0, 100);
    set_level(1'b1, 16);
    set_level(1'b0, 496);
    send_rand(12);
    set_level(1'b0, 300);
    check_all("low_100");

    // Reset after 5 symbols; the rest of the frame must not decode.
    set_level(1'b0, 496);
    send_rand(5);
    set_level(1'b1, 16);
    set_level(1'b0, 8);
    check_all("pre_rst");
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.push_back('{cyc: cyc, lvl: 1'b0, is_rst: 1'b1});
    set_level(1'b0, 40);
    send_rand(6);
    set_level(1'b0, 300);
    check_all("post_rst");

    // Recovery with a fresh sync.
    set_level(1'b0, 496);
    send_rand(12);
    set_level(1'b0, 300);
    check_all("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
